// File: rtl/shift_ctrl_pkg.sv
// Shared encodings and constants for the serial shift-register sequencer.
// Imported by the top and the clock-enable divider.
package shift_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Words leave on SI most-significant bit first.
    localparam bit MSB_FIRST = 1'b1;

    function automatic int tick_w(input int width, input int depth);
        return $clog2(width + depth);
    endfunction

    localparam int TICK_W = tick_w(8, 4);

endpackage

// File: rtl/clken_divider.sv
// Rate generator: one-cycle tick every div+1 enabled cycles.
// The counter restarts from zero whenever en drops, so the first tick is div cycles in.
module clken_divider
    import shift_ctrl_pkg::*;
#(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;

    assign tick = en && (cnt == div);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (!en || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/shift_register_ctrl.sv
// Sequencer for an external DEPTH-stage serial shift register: shifts a word out
// on SI at a programmable rate and captures the word returning on SO.
module shift_register_ctrl
    import shift_ctrl_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    input  logic [DIV_W-1:0] div,
    output logic             sr_clken,
    output logic             sr_si,
    input  logic             sr_so,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             busy
);

    localparam int TW = tick_w(WIDTH, DEPTH);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] tx_q;
    logic [DIV_W-1:0] div_q;
    logic [TW-1:0]    t;
    logic             si_q;
    logic [WIDTH-1:0] rx_shift;
    logic [WIDTH-1:0] rx_next;
    logic [IW-1:0]    idx;
    logic             bit_now;
    logic             tick;
    logic             in_shift;
    logic             accept;
    logic             last_tick;

    assign in_shift  = (state == SHIFT);
    assign accept    = (state == IDLE) && tx_valid;
    assign last_tick = tick && (t == TW'(WIDTH + DEPTH - 1));
    assign rx_next   = {rx_shift[WIDTH-2:0], sr_so};

    clken_divider #(
        .DIV_W(DIV_W)
    ) u_div (
        .clk (clk),
        .rst (rst),
        .en  (in_shift),
        .div (div_q),
        .tick(tick)
    );

    // Bit for the current tick index; zero once the word is out (flush).
    always_comb begin
        idx     = IW'(MSB_FIRST ? (WIDTH - 1 - int'(t)) : int'(t));
        bit_now = 1'b0;
        if (int'(t) < WIDTH) begin
            bit_now = tx_q[idx];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (tx_valid) state_nx = SHIFT;
            SHIFT:   if (last_tick) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign tx_ready = (state == IDLE);
    assign busy     = !tx_ready;
    assign rx_valid = (state == DONE);
    assign sr_clken = tick;
    // SI is live on a tick edge and holds the last shifted bit in between.
    assign sr_si    = in_shift && (tick ? bit_now : si_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_q     <= '0;
            div_q    <= '0;
            t        <= '0;
            si_q     <= 1'b0;
            rx_shift <= '0;
            rx_data  <= '0;
        end else begin
            if (accept) begin
                tx_q     <= tx_data;
                div_q    <= div;
                t        <= '0;
                rx_shift <= '0;
            end
            if (!in_shift) begin
                si_q <= 1'b0;
            end else if (tick) begin
                si_q <= bit_now;
                t    <= t + TW'(1);
                // SO carries stale contents until the first bit has crossed DEPTH stages.
                if (int'(t) >= DEPTH) begin
                    rx_shift <= rx_next;
                end
                if (last_tick) begin
                    rx_data <= rx_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_shift_register_ctrl.sv
// Bench for shift_register_ctrl: loopback DEPTH=4 register, transfer-level model,
// per-cycle compare plus directed literal checks and randomized traffic.
module tb_shift_register_ctrl;

    localparam int W = 8;
    localparam int D = 4;
    localparam int L = W + D;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] tx_data = '0;
    logic         tx_valid = 1'b0;
    logic         tx_ready;
    logic [7:0]   div = '0;
    logic         sr_clken;
    logic         sr_si;
    logic         sr_so;
    logic [W-1:0] rx_data;
    logic         rx_valid;
    logic         busy;

    int n_tests = 0;
    int n_fail  = 0;

    shift_register_ctrl #(
        .WIDTH(W),
        .DEPTH(D),
        .DIV_W(8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .div     (div),
        .sr_clken(sr_clken),
        .sr_si   (sr_si),
        .sr_so   (sr_so),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    // External DEPTH-stage register; never cleared, so it starts with junk.
    logic [D-1:0] sreg = 4'b1010;
    logic         sr_force = 1'b0;

    always @(posedge clk) begin
        if (sr_clken) sreg <= {sreg[D-2:0], sr_si};
    end
    assign sr_so = sr_force ? 1'b0 : sreg[D-1];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transfer-level model: cycle c (1-based) after the accept edge.
    function automatic int total(input int n);
        return L * (n + 1) + 1;
    endfunction

    logic         m_active = 1'b0;
    int           m_c = 0;
    logic [W-1:0] m_d = '0;
    int           m_n = 0;
    logic [W-1:0] m_rx = '0;
    int           m_done = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_active <= 1'b0;
            m_c      <= 0;
            m_rx     <= '0;
        end else if (m_active) begin
            if (m_c == total(m_n)) begin
                m_active <= 1'b0;
            end else begin
                m_c <= m_c + 1;
                if (m_c == total(m_n) - 1) begin
                    m_rx   <= sr_force ? '0 : m_d;
                    m_done <= m_done + 1;
                end
            end
        end else if (tx_valid) begin
            m_active <= 1'b1;
            m_c      <= 1;
            m_d      <= tx_data;
            m_n      <= int'(div);
        end
    end

    int   dut_valids = 0;
    int   p, k;
    logic e_sh, e_clken, e_si, e_valid;

    always @(negedge clk) begin
        p       = m_n + 1;
        k       = m_c / p;
        e_sh    = m_active && (m_c < total(m_n));
        e_clken = e_sh && (m_c % p == 0);
        e_si    = 1'b0;
        if (e_sh && k >= 1 && k <= W) e_si = m_d[3'(W - k)];
        e_valid = m_active && (m_c == total(m_n));
        if (rx_valid) dut_valids++;
        chk("busy", 32'(busy), 32'(m_active));
        chk("tx_ready", 32'(tx_ready), 32'(!m_active));
        chk("sr_clken", 32'(sr_clken), 32'(e_clken));
        chk("sr_si", 32'(sr_si), 32'(e_si));
        chk("rx_valid", 32'(rx_valid), 32'(e_valid));
        chk("rx_data", 32'(rx_data), 32'(m_rx));
    end

    // Per-cycle observation statistics for the directed tests.
    int           cyc, nvalid, nclk, first_clk, last_clk;
    int           min_gap, max_gap, busy_cnt, run, max_run;
    int           vcyc[2];
    logic [W-1:0] vdata[2];

    task automatic reset_stats();
        cyc = 0; nvalid = 0; nclk = 0; first_clk = -1; last_clk = -1;
        min_gap = 1000; max_gap = 0; busy_cnt = 0; run = 0; max_run = 0;
        vcyc[0] = -1; vcyc[1] = -1; vdata[0] = '0; vdata[1] = '0;
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        if (busy) busy_cnt++;
        if (sr_clken) begin
            nclk++;
            if (last_clk >= 0) begin
                if (cyc - last_clk < min_gap) min_gap = cyc - last_clk;
                if (cyc - last_clk > max_gap) max_gap = cyc - last_clk;
            end else begin
                first_clk = cyc;
            end
            last_clk = cyc;
            run++;
            if (run > max_run) max_run = run;
        end else begin
            run = 0;
        end
        if (rx_valid) begin
            if (nvalid < 2) begin
                vcyc[nvalid]  = cyc;
                vdata[nvalid] = rx_data;
            end
            nvalid++;
        end
    endtask

    task automatic start(input logic [W-1:0] d, input logic [7:0] dv);
        tx_data  = d;
        div      = dv;
        tx_valid = 1'b1;
        reset_stats();
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset tx_ready", 32'(tx_ready), 32'd1);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset rx_data", 32'(rx_data), 32'd0);
        chk("reset sr_clken", 32'(sr_clken), 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // 1: div=0, A5
        start(8'hA5, 8'd0);
        step();
        tx_valid = 1'b0;
        repeat (19) step();
        chk("t1 rx_data", 32'(vdata[0]), 32'h A5);
        chk("t1 rx_valid cycle", 32'(vcyc[0]), 32'd13);
        chk("t1 clken count", 32'(nclk), 32'd12);
        chk("t1 clken run", 32'(max_run), 32'd12);
        chk("t1 first clken", 32'(first_clk), 32'd1);
        chk("t1 busy cycles", 32'(busy_cnt), 32'd13);
        chk("t1 rx_valid pulses", 32'(nvalid), 32'd1);

        // 2: div=2, 5A
        start(8'h5A, 8'd2);
        step();
        tx_valid = 1'b0;
        repeat (44) step();
        chk("t2 rx_data", 32'(vdata[0]), 32'h5A);
        chk("t2 clken count", 32'(nclk), 32'd12);
        chk("t2 min gap", 32'(min_gap), 32'd3);
        chk("t2 max gap", 32'(max_gap), 32'd3);
        chk("t2 pulse width", 32'(max_run), 32'd1);
        chk("t2 rx_valid cycle", 32'(vcyc[0]), 32'd37);

        // 3: back-to-back with tx_valid held
        start(8'h3C, 8'd0);
        step();
        tx_data = 8'hC3;
        while (cyc < 15) step();
        tx_valid = 1'b0;
        repeat (20) step();
        chk("t3 pulses", 32'(nvalid), 32'd2);
        chk("t3 first cycle", 32'(vcyc[0]), 32'd13);
        chk("t3 second cycle", 32'(vcyc[1]), 32'd27);
        chk("t3 first data", 32'(vdata[0]), 32'h3C);
        chk("t3 second data", 32'(vdata[1]), 32'hC3);

        // 4: reset after 5 ticks, then FF through stale contents
        start(8'hF0, 8'd0);
        step();
        tx_valid = 1'b0;
        repeat (4) step();
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("t4 busy", 32'(busy), 32'd0);
        chk("t4 tx_ready", 32'(tx_ready), 32'd1);
        chk("t4 sr_clken", 32'(sr_clken), 32'd0);
        chk("t4 sr_si", 32'(sr_si), 32'd0);
        chk("t4 rx_valid", 32'(rx_valid), 32'd0);
        chk("t4 rx_data", 32'(rx_data), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        reset_stats();
        repeat (10) step();
        chk("t4 no rx_valid", 32'(nvalid), 32'd0);
        start(8'hFF, 8'd0);
        step();
        tx_valid = 1'b0;
        repeat (19) step();
        chk("t4 rx_data", 32'(vdata[0]), 32'hFF);

        // 5: inputs changed and tx_valid held during SHIFT
        start(8'h81, 8'd1);
        step();
        tx_data = 8'h00;
        div     = 8'd0;
        while (cyc < 20) step();
        tx_valid = 1'b0;
        repeat (20) step();
        chk("t5 rx_data", 32'(vdata[0]), 32'h81);
        chk("t5 pulses", 32'(nvalid), 32'd1);
        chk("t5 rx_valid cycle", 32'(vcyc[0]), 32'd25);

        // 6: SO stuck at 0
        sr_force = 1'b1;
        start(8'hFF, 8'd0);
        step();
        tx_valid = 1'b0;
        repeat (19) step();
        sr_force = 1'b0;
        chk("t6 rx_data", 32'(vdata[0]), 32'h00);
        chk("t6 pulses", 32'(nvalid), 32'd1);

        // Randomized traffic, checked cycle by cycle against the model
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            tx_valid = ($urandom_range(0, 3) == 0);
            tx_data  = W'($urandom);
            div      = 8'($urandom_range(0, 3));
        end
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (60) @(negedge clk);
        #1;
        chk("completions", 32'(dut_valids), 32'(m_done));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
